// File: rtl/tiny_dnn_seq.sv
// Convolution loop sequencer: walks oc/y/x/ic/ky/kx and streams {src, wgt, dst}
// address beats with accumulate markers, using running base registers instead of multipliers.
module tiny_dnn_seq #(
  parameter int AW = 12
) (
  input  logic          S_AXI_ACLK,
  input  logic          S_AXI_ARESETN,
  input  logic          run,
  input  logic          wwrite,
  input  logic          bwrite,
  input  logic [3:0]    id,
  input  logic [9:0]    is,
  input  logic [4:0]    iw,
  input  logic [3:0]    od,
  input  logic [9:0]    os,
  input  logic [4:0]    oh,
  input  logic [4:0]    ow,
  input  logic [9:0]    fs,
  input  logic [9:0]    ks,
  input  logic [4:0]    kh,
  input  logic [4:0]    kw,
  output logic [AW-1:0] src_addr,
  output logic [AW-1:0] wgt_addr,
  output logic [AW-1:0] dst_addr,
  output logic          acc_first,
  output logic          acc_last,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_n;

  logic run_d, start, zero_sz;
  logic [AW-1:0] is_e, iw_e, os_e, fs_e, ks_e, kw_e;

  logic [4:0] kx, ky, x, y, n_kx, n_ky, n_x, n_y;
  logic [3:0] ic, oc, n_ic, n_oc;
  // s_c = ic*is, s_y = y*iw, s_r = (y+ky)*iw, col = x+kx
  logic [AW-1:0] s_c, s_y, s_r, col, n_s_c, n_s_y, n_s_r, n_col;
  // w_f = oc*fs, w_c = ic*ks, w_r = ky*kw
  logic [AW-1:0] w_f, w_c, w_r, n_w_f, n_w_c, n_w_r;
  // d_c = oc*os, d_p = y*ow + x (steps by one per output pixel)
  logic [AW-1:0] d_c, d_p, n_d_c, n_d_p;

  assign is_e = AW'(is);
  assign iw_e = AW'(iw);
  assign os_e = AW'(os);
  assign fs_e = AW'(fs);
  assign ks_e = AW'(ks);
  assign kw_e = AW'(kw);

  assign start   = run & ~run_d & ~wwrite & ~bwrite;
  assign zero_sz = (od == '0) | (oh == '0) | (ow == '0) | (id == '0) | (kh == '0) | (kw == '0);

  assign valid = (state == ISSUE);
  assign busy  = (state == ISSUE);
  assign done  = (state == DONE);

  always_comb begin
    state_n = state;
    n_kx = kx;  n_ky = ky;  n_ic = ic;  n_x = x;  n_y = y;  n_oc = oc;
    n_s_c = s_c;  n_s_y = s_y;  n_s_r = s_r;  n_col = col;
    n_w_f = w_f;  n_w_c = w_c;  n_w_r = w_r;
    n_d_c = d_c;  n_d_p = d_p;
    case (state)
      IDLE: begin
        if (start) begin
          if (zero_sz) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            n_kx = '0;  n_ky = '0;  n_ic = '0;  n_x = '0;  n_y = '0;  n_oc = '0;
            n_s_c = '0;  n_s_y = '0;  n_s_r = '0;  n_col = '0;
            n_w_f = '0;  n_w_c = '0;  n_w_r = '0;
            n_d_c = '0;  n_d_p = '0;
          end
        end
      end
      ISSUE: begin
        if (!run) begin
          state_n = IDLE;
        end else if (ready) begin
          // Each wrap rebuilds the inner bases from the enclosing level's base.
          if (kx != kw - 5'd1) begin
            n_kx  = kx + 5'd1;
            n_col = col + AW'(1);
          end else begin
            n_kx  = '0;
            n_col = AW'(x);
            if (ky != kh - 5'd1) begin
              n_ky  = ky + 5'd1;
              n_s_r = s_r + iw_e;
              n_w_r = w_r + kw_e;
            end else begin
              n_ky  = '0;
              n_s_r = s_y;
              n_w_r = '0;
              if (ic != id - 4'd1) begin
                n_ic  = ic + 4'd1;
                n_s_c = s_c + is_e;
                n_w_c = w_c + ks_e;
              end else begin
                n_ic  = '0;
                n_s_c = '0;
                n_w_c = '0;
                n_d_p = d_p + AW'(1);
                if (x != ow - 5'd1) begin
                  n_x   = x + 5'd1;
                  n_col = AW'(x) + AW'(1);
                end else begin
                  n_x   = '0;
                  n_col = '0;
                  if (y != oh - 5'd1) begin
                    n_y   = y + 5'd1;
                    n_s_y = s_y + iw_e;
                    n_s_r = s_y + iw_e;
                  end else begin
                    n_y   = '0;
                    n_s_y = '0;
                    n_s_r = '0;
                    n_d_p = '0;
                    if (oc != od - 4'd1) begin
                      n_oc  = oc + 4'd1;
                      n_w_f = w_f + fs_e;
                      n_d_c = d_c + os_e;
                    end else begin
                      state_n = DONE;
                    end
                  end
                end
              end
            end
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state <= IDLE;
      run_d <= 1'b0;
      kx <= '0;  ky <= '0;  ic <= '0;  x <= '0;  y <= '0;  oc <= '0;
      s_c <= '0;  s_y <= '0;  s_r <= '0;  col <= '0;
      w_f <= '0;  w_c <= '0;  w_r <= '0;
      d_c <= '0;  d_p <= '0;
      src_addr  <= '0;
      wgt_addr  <= '0;
      dst_addr  <= '0;
      acc_first <= 1'b0;
      acc_last  <= 1'b0;
    end else begin
      state <= state_n;
      run_d <= run;
      kx <= n_kx;  ky <= n_ky;  ic <= n_ic;  x <= n_x;  y <= n_y;  oc <= n_oc;
      s_c <= n_s_c;  s_y <= n_s_y;  s_r <= n_s_r;  col <= n_col;
      w_f <= n_w_f;  w_c <= n_w_c;  w_r <= n_w_r;
      d_c <= n_d_c;  d_p <= n_d_p;
      if (state_n == ISSUE) begin
        src_addr  <= n_s_c + n_s_r + n_col;
        wgt_addr  <= n_w_f + n_w_c + n_w_r + AW'(n_kx);
        dst_addr  <= n_d_c + n_d_p;
        acc_first <= (n_ic == '0) && (n_ky == '0) && (n_kx == '0);
        acc_last  <= (n_ic == id - 4'd1) && (n_ky == kh - 5'd1) && (n_kx == kw - 5'd1);
      end
    end
  end

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Directed bench for tiny_dnn_seq: beat sequences, backpressure, zero/ignored start, abort, reset.
module tb_tiny_dnn_seq;
  localparam int AW = 12;

  logic          S_AXI_ACLK = 1'b0;
  logic          S_AXI_ARESETN = 1'b0;
  logic          run = 1'b0, wwrite = 1'b0, bwrite = 1'b0, ready = 1'b0;
  logic [3:0]    id = '0, od = '0;
  logic [9:0]    is = '0, os = '0, fs = '0, ks = '0;
  logic [4:0]    iw = '0, oh = '0, ow = '0, kh = '0, kw = '0;
  logic [AW-1:0] src_addr, wgt_addr, dst_addr;
  logic          acc_first, acc_last, valid, busy, done;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  tiny_dnn_seq #(.AW(AW)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
    .run(run), .wwrite(wwrite), .bwrite(bwrite),
    .id(id), .is(is), .iw(iw), .od(od), .os(os), .oh(oh), .ow(ow),
    .fs(fs), .ks(ks), .kh(kh), .kw(kw),
    .src_addr(src_addr), .wgt_addr(wgt_addr), .dst_addr(dst_addr),
    .acc_first(acc_first), .acc_last(acc_last),
    .valid(valid), .ready(ready), .busy(busy), .done(done)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int s, input int w, input int d, input bit f, input bit l);
    return {26'd0, s[11:0], w[11:0], d[11:0], f, l};
  endfunction

  function automatic logic [63:0] outs();
    return {26'd0, src_addr, wgt_addr, dst_addr, acc_first, acc_last};
  endfunction

  task automatic cfg(input int a_id, input int a_is, input int a_iw, input int a_od,
                     input int a_os, input int a_oh, input int a_ow, input int a_fs,
                     input int a_ks, input int a_kh, input int a_kw);
    id = a_id[3:0];  is = a_is[9:0];  iw = a_iw[4:0];  od = a_od[3:0];
    os = a_os[9:0];  oh = a_oh[4:0];  ow = a_ow[4:0];  fs = a_fs[9:0];
    ks = a_ks[9:0];  kh = a_kh[4:0];  kw = a_kw[4:0];
  endtask

  // Raise run, collect accepted beats against exp_q; abort_at >= 0 drops run after that many beats.
  task automatic run_seq(input string nm, input bit rnd, input int abort_at);
    logic [63:0] got[$];
    logic [63:0] held;
    int nb = 0, ndone = 0, done_cyc = -1, last_acc = -1, abort_cyc = -1, n_want;
    bit hold = 0, aborted = 0;
    @(negedge S_AXI_ACLK);
    run = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge S_AXI_ACLK);
      if (hold) begin
        check({nm, "_hold_valid"}, 64'(valid), 64'd1);
        check({nm, "_hold_beat"}, outs(), held);
      end
      hold = 0;
      if (aborted) begin
        if (cyc == abort_cyc + 1) check({nm, "_abort_valid"}, 64'(valid), 64'd0);
        if (done) ndone++;
        if (cyc == abort_cyc + 5) break;
        continue;
      end
      if (abort_at >= 0 && nb == abort_at) begin
        run = 1'b0;
        ready = 1'b0;
        aborted = 1;
        abort_cyc = cyc;
        continue;
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (valid && ready) begin
        if (nb == 0) check({nm, "_busy"}, 64'(busy), 64'd1);
        got.push_back(outs());
        last_acc = cyc;
        nb++;
      end else if (valid) begin
        hold = 1;
        held = outs();
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) break;
    end
    run = 1'b0;
    ready = 1'b0;
    n_want = aborted ? abort_at : exp_q.size();
    check({nm, "_beats"}, 64'(nb), 64'(n_want));
    for (int i = 0; i < nb && i < n_want; i++)
      check($sformatf("%s_beat%0d", nm, i), got[i], exp_q[i]);
    check({nm, "_done_count"}, 64'(ndone), aborted ? 64'd0 : 64'd1);
    if (!aborted && n_want > 0)
      check({nm, "_done_time"}, 64'(done_cyc), 64'(last_acc + 1));
    check({nm, "_busy_after"}, 64'(busy), 64'd0);
    @(negedge S_AXI_ACLK);
  endtask

  task automatic load_conv2x2();
    cfg(1, 9, 3, 1, 4, 2, 2, 4, 4, 2, 2);
    exp_q.delete();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++)
        for (int ky = 0; ky < 2; ky++)
          for (int kx = 0; kx < 2; kx++)
            exp_q.push_back(pk((y + ky) * 3 + x + kx, ky * 2 + kx, y * 2 + x,
                               ky == 0 && kx == 0, ky == 1 && kx == 1));
  endtask

  initial begin
    int nv, nd;
    repeat (3) @(negedge S_AXI_ACLK);
    check("reset_flags", 64'({valid, busy, done}), 64'd0);
    check("reset_beat", outs(), 64'd0);
    S_AXI_ARESETN = 1'b1;
    @(negedge S_AXI_ACLK);

    cfg(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    exp_q.delete();
    exp_q.push_back(pk(0, 0, 0, 1, 1));
    run_seq("min", 0, -1);

    load_conv2x2();
    // Spot-check the hand-derived table entries called out for this convolution.
    check("tbl_b3", exp_q[3], pk(4, 3, 0, 0, 1));
    check("tbl_b8", exp_q[8], pk(3, 0, 2, 1, 0));
    check("tbl_b15", exp_q[15], pk(8, 3, 3, 0, 1));
    run_seq("conv", 0, -1);

    cfg(2, 9, 3, 2, 1, 1, 1, 2, 1, 1, 1);
    exp_q.delete();
    exp_q.push_back(pk(0, 0, 0, 1, 0));
    exp_q.push_back(pk(9, 1, 0, 0, 1));
    exp_q.push_back(pk(0, 2, 1, 1, 0));
    exp_q.push_back(pk(9, 3, 1, 0, 1));
    run_seq("mch", 0, -1);

    load_conv2x2();
    run_seq("bp", 1, -1);

    cfg(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
    exp_q.delete();
    run_seq("zero", 0, -1);

    cfg(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    for (int m = 0; m < 2; m++) begin
      wwrite = (m == 0);
      bwrite = (m == 1);
      @(negedge S_AXI_ACLK);
      run = 1'b1;
      ready = 1'b1;
      nv = 0;
      nd = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge S_AXI_ACLK);
        if (valid) nv++;
        if (done) nd++;
      end
      check($sformatf("ignored%0d_valid", m), 64'(nv), 64'd0);
      check($sformatf("ignored%0d_done", m), 64'(nd), 64'd0);
      run = 1'b0;
      ready = 1'b0;
      wwrite = 1'b0;
      bwrite = 1'b0;
      @(negedge S_AXI_ACLK);
    end

    load_conv2x2();
    run_seq("abort", 0, 6);
    run_seq("restart", 0, -1);

    load_conv2x2();
    @(negedge S_AXI_ACLK);
    run = 1'b1;
    ready = 1'b1;
    repeat (5) @(negedge S_AXI_ACLK);
    check("pre_rst_valid", 64'(valid), 64'd1);
    S_AXI_ARESETN = 1'b0;
    run = 1'b0;
    ready = 1'b0;
    @(negedge S_AXI_ACLK);
    check("mid_rst_flags", 64'({valid, busy, done}), 64'd0);
    check("mid_rst_beat", outs(), 64'd0);
    S_AXI_ARESETN = 1'b1;
    @(negedge S_AXI_ACLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
